// File: rtl/peripheral_responder_pkg.sv
// Shared definitions for the peripheral responder:
// register offsets, default base address and FSM states.
package peripheral_pkg;

   localparam logic [31:0] DEF_BASE_ADDR = 32'h0400_0100;

   localparam logic [7:0] OFF_STATUS   = 8'h00;
   localparam logic [7:0] OFF_DONE     = 8'h04;
   localparam logic [7:0] OFF_CYC_LO   = 8'h08;
   localparam logic [7:0] OFF_CYC_HI   = 8'h0C;
   localparam logic [7:0] OFF_TX_DATA  = 8'h10;
   localparam logic [7:0] OFF_CYC_CTRL = 8'h14;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_STALL,
      ST_RESP,
      ST_GAP
   } state_e;

endpackage

// File: rtl/peripheral_responder_if.sv
// Request/response bus between the switch peripheral port
// and the responder.
interface peripheral_responder_if;

   logic        req_i;
   logic        wren_i;
   logic [31:0] addr_i;
   logic [31:0] data_i;
   logic        done_o;
   logic [31:0] data_o;

   modport master (
      output req_i, wren_i, addr_i, data_i,
      input  done_o, data_o
   );

   modport slave (
      input  req_i, wren_i, addr_i, data_i,
      output done_o, data_o
   );

endinterface

// File: rtl/peripheral_responder_tx_fifo.sv
// Byte-wide TX FIFO, power-of-two depth, pointers wrap
// naturally at DEPTH.
module peripheral_tx_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                     clock_i,
   input  logic                     reset_i,
   input  logic                     push,
   input  logic                     pop,
   input  logic [7:0]               wdata,
   output logic [7:0]               rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   cnt;

   always_ff @(posedge clock_i)
      if (push) mem[wr_ptr] <= wdata;

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      cnt <= cnt + 1'b1;
         else if (pop && !push) cnt <= cnt - 1'b1;
      end
   end

   assign full  = (cnt == (AW+1)'(DEPTH));
   assign empty = (cnt == '0);
   assign count = cnt;
   assign rdata = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: rtl/peripheral_responder.sv
// Memory-mapped responder: status/flag registers, 64-bit
// cycle counter with HI shadow, and a TX byte FIFO.
module peripheral_responder
   import peripheral_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
   parameter int          TX_DEPTH  = 8
) (
   input  logic                         clock_i,
   input  logic                         reset_i,
   peripheral_responder_if.slave        bus,
   output logic                         flag_done_o,
   output logic                         tx_valid_o,
   output logic [7:0]                   tx_data_o,
   input  logic                         tx_ready_i
);

   localparam int CW = $clog2(TX_DEPTH) + 1;

   state_e        state;
   state_e        next;
   logic          wren_q;
   logic [31:2]   addr_q;
   logic [7:0]    wdata_q;
   logic [31:0]   rdata_q;
   logic [31:0]   rd_mux;
   logic [63:0]   cyc_q;
   logic [31:0]   shadow_q;
   logic          enable_q;
   logic          push, pop, full, empty, clear;
   logic [CW-1:0] count;
   logic [7:0]    off;
   logic          hit, tx_wr, done_wr, ctrl_wr, lo_rd;
   logic          unused_bits;

   assign unused_bits = ^{bus.data_i[31:8], bus.addr_i[1:0]};

   assign off     = {addr_q[7:2], 2'b00};
   assign hit     = (addr_q[31:8] == BASE_ADDR[31:8]);
   assign tx_wr   = hit && wren_q && (off == OFF_TX_DATA);
   assign done_wr = hit && wren_q && (off == OFF_DONE);
   assign ctrl_wr = hit && wren_q && (off == OFF_CYC_CTRL);
   assign lo_rd   = hit && !wren_q && (off == OFF_CYC_LO);

   always_comb begin
      rd_mux = '0;
      if (hit && !wren_q) begin
         case (off)
            OFF_STATUS:
               rd_mux = {16'h0, 8'(count), 6'h0, full, empty};
            OFF_DONE:     rd_mux = {31'h0, flag_done_o};
            OFF_CYC_LO:   rd_mux = cyc_q[31:0];
            OFF_CYC_HI:   rd_mux = shadow_q;
            OFF_CYC_CTRL: rd_mux = {31'h0, enable_q};
            default:      rd_mux = '0;
         endcase
      end
   end

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) state <= ST_IDLE;
      else          state <= next;
   end

   always_comb begin
      next = state;
      unique case (state)
         ST_IDLE:   if (bus.req_i) next = ST_ACCESS;
         ST_ACCESS: next = (tx_wr && full) ? ST_STALL : ST_RESP;
         ST_STALL:  if (!full) next = ST_RESP;
         ST_RESP:   next = ST_GAP;
         ST_GAP:    next = ST_IDLE;
         default:   next = ST_IDLE;
      endcase
   end

   always_comb begin
      push       = 1'b0;
      clear      = 1'b0;
      bus.done_o = 1'b0;
      bus.data_o = '0;
      unique case (1'b1)
         state == ST_ACCESS: begin
            push  = tx_wr && !full;
            clear = ctrl_wr && wdata_q[1];
         end
         state == ST_STALL: push = !full;
         state == ST_RESP: begin
            bus.done_o = 1'b1;
            bus.data_o = rdata_q;
         end
         default: ;
      endcase
   end

   // Shadow is captured on the same edge that samples LO.
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         wren_q      <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         cyc_q       <= '0;
         shadow_q    <= '0;
         enable_q    <= 1'b1;
         flag_done_o <= 1'b0;
      end else begin
         if (state == ST_IDLE && bus.req_i) begin
            wren_q  <= bus.wren_i;
            addr_q  <= bus.addr_i[31:2];
            wdata_q <= bus.data_i[7:0];
         end
         if (state == ST_ACCESS) begin
            rdata_q <= rd_mux;
            if (lo_rd)   shadow_q <= cyc_q[63:32];
            if (done_wr && wdata_q[0]) flag_done_o <= 1'b1;
            if (ctrl_wr) enable_q <= wdata_q[0];
         end
         if (clear)         cyc_q <= '0;
         else if (enable_q) cyc_q <= cyc_q + 64'd1;
      end
   end

   assign pop        = tx_valid_o && tx_ready_i;
   assign tx_valid_o = !empty;

   peripheral_tx_fifo #(
      .DEPTH (TX_DEPTH)
   ) u_fifo (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .push    (push),
      .pop     (pop),
      .wdata   (wdata_q),
      .rdata   (tx_data_o),
      .full    (full),
      .empty   (empty),
      .count   (count)
   );

endmodule

// File: tb/tb_peripheral_responder.sv
// Randomized bench for peripheral_responder against a
// queue-based register/FIFO model.
module tb_peripheral_responder;

   localparam logic [31:0] BASE = 32'h0400_0100;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       flag_done;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready = 1'b0;

   int checks = 0;
   int failures = 0;

   logic [7:0] q [$];
   logic       m_flag = 1'b0;

   peripheral_responder_if bus ();

   peripheral_responder dut (
      .clock_i     (clk),
      .reset_i     (rst_n),
      .bus         (bus),
      .flag_done_o (flag_done),
      .tx_valid_o  (tx_valid),
      .tx_data_o   (tx_data),
      .tx_ready_i  (tx_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] status_exp();
      return {16'h0, 8'(q.size()), 6'h0,
              q.size() == 8, q.size() == 0};
   endfunction

   task automatic txn(input logic wr, input logic [31:0] a,
                      input logic [31:0] d,
                      output logic [31:0] rd, output int lat);
      logic got;
      got = 1'b0;
      rd  = '0;
      lat = 0;
      @(negedge clk);
      bus.req_i  = 1'b1;
      bus.wren_i = wr;
      bus.addr_i = a;
      bus.data_i = d;
      for (int i = 0; i < 20 && !got; i++) begin
         @(posedge clk);
         #1;
         lat++;
         if (bus.done_o) begin
            got = 1'b1;
            rd  = bus.data_o;
         end else if (bus.data_o !== 32'h0) begin
            check("data_idle", bus.data_o, 0);
         end
      end
      if (!got) check("txn_timeout", 0, 1);
      bus.req_i = 1'b0;
      @(posedge clk);
      @(posedge clk);
   endtask

   task automatic do_rd(input string tag, input logic [31:0] a,
                        input logic [31:0] exp);
      logic [31:0] rd;
      int lat;
      txn(1'b0, a, $urandom, rd, lat);
      check(tag, rd, exp);
      check({tag, "_lat"}, lat, 2);
   endtask

   task automatic do_wr(input string tag, input logic [31:0] a,
                        input logic [31:0] d);
      logic [31:0] rd;
      int lat;
      txn(1'b1, a, d, rd, lat);
      check({tag, "_lat"}, lat, 2);
      check({tag, "_rdata"}, rd, 0);
   endtask

   task automatic push_tx(input logic [7:0] b);
      do_wr("tx_push", BASE + 32'h10, {$urandom, b} >> 0);
      q.push_back(b);
   endtask

   task automatic pop_one();
      @(negedge clk);
      check("tx_valid", tx_valid, q.size() != 0);
      if (q.size() != 0) check("tx_data", tx_data, q[0]);
      else               check("tx_data_empty", tx_data, 0);
      tx_ready = 1'b1;
      @(posedge clk);
      #1;
      tx_ready = 1'b0;
      if (q.size() != 0) void'(q.pop_front());
   endtask

   task automatic stall_push(input logic [7:0] b, output logic got);
      got = 1'b0;
      @(negedge clk);
      bus.req_i  = 1'b1;
      bus.wren_i = 1'b1;
      bus.addr_i = BASE + 32'h10;
      bus.data_i = {24'h0, b};
      repeat (4) begin
         @(posedge clk);
         #1;
         check("stall_nodone", bus.done_o, 0);
      end
   endtask

   logic [31:0] rd, lo, hi;
   int lat;
   logic got;
   logic [31:0] a, d;
   int op;

   initial begin
      #200000;
      $display("FAIL global_timeout got=1 exp=0");
      $fatal(1, "timeout");
   end

   initial begin
      bus.req_i  = 1'b0;
      bus.wren_i = 1'b0;
      bus.addr_i = '0;
      bus.data_i = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_done", bus.done_o, 0);
      check("rst_data", bus.data_o, 0);
      check("rst_flag", flag_done, 0);
      check("rst_txv", tx_valid, 0);
      check("rst_txd", tx_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);

      do_wr("done0", BASE + 32'h04, 32'h0);
      check("flag_stays0", flag_done, 0);
      do_rd("miss_rd", 32'h0400_0200, 32'h0);
      do_rd("unmapped_rd", 32'h0400_0118, 32'h0);
      do_rd("status_rst", BASE, status_exp());
      do_rd("ctrl_rst", BASE + 32'h14, 32'h1);
      do_rd("hi_rst", BASE + 32'h0C, 32'h0);

      for (int it = 0; it < 60; it++) begin
         op = $urandom_range(0, 6);
         d  = $urandom;
         case (op)
            0: begin
               do_wr("done_wr", BASE + 32'h04 + (d & 3), d);
               if (d[0]) m_flag = 1'b1;
               check("flag", flag_done, m_flag);
            end
            1: do_rd("done_rd", BASE + 32'h04, {31'h0, m_flag});
            2: do_rd("status", BASE + ($urandom & 3), status_exp());
            3: if (q.size() < 8) push_tx(d[7:0]);
            4: pop_one();
            5: begin
               a = $urandom;
               if (a[31:8] == BASE[31:8]) a[31] = ~a[31];
               do_wr("miss_wr", a, d);
               do_rd("miss_rd", a, 32'h0);
            end
            default: begin
               a = BASE + ($urandom_range(6, 63) << 2);
               do_rd("unmapped", a, 32'h0);
               do_rd("txdata_rd", BASE + 32'h10, 32'h0);
            end
         endcase
      end

      do_wr("done1", 32'h0400_0104, 32'h1);
      m_flag = 1'b1;
      @(posedge clk);
      #1;
      check("flag_set", flag_done, 1);
      do_rd("done_rd1", 32'h0400_0104, 32'h1);

      while (q.size() != 0) pop_one();
      for (int i = 0; i < 8; i++) push_tx(8'h41 + 8'(i));
      do_rd("status_full", BASE, 32'h0000_0802);
      stall_push(8'h49, got);
      @(negedge clk);
      check("stall_head", tx_data, 8'h41);
      tx_ready = 1'b1;
      @(posedge clk);
      #1;
      tx_ready = 1'b0;
      for (int i = 0; i < 6 && !got; i++) begin
         @(posedge clk);
         #1;
         if (bus.done_o) got = 1'b1;
      end
      check("stall_done", got, 1);
      bus.req_i = 1'b0;
      @(posedge clk);
      @(posedge clk);
      void'(q.pop_front());
      q.push_back(8'h49);
      do_rd("status_after", BASE, 32'h0000_0802);
      check("flag_sticky", flag_done, 1);
      while (q.size() != 0) pop_one();
      check("drained", tx_valid, 0);

      for (int i = 0; i < 8; i++) push_tx(8'(i));
      stall_push(8'hEE, got);
      @(negedge clk);
      rst_n = 1'b0;
      bus.req_i = 1'b0;
      #1;
      check("rstst_done", bus.done_o, 0);
      check("rstst_txv", tx_valid, 0);
      check("rstst_txd", tx_data, 0);
      check("rstst_flag", flag_done, 0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      q.delete();
      m_flag = 1'b0;
      do_rd("post_rst_status", BASE, 32'h0000_0001);
      do_rd("post_rst_flag", BASE + 32'h04, 32'h0);

      do_wr("ctrl_clr", BASE + 32'h14, 32'h2);
      do_rd("ctrl_off", BASE + 32'h14, 32'h0);
      do_rd("lo_frozen", BASE + 32'h08, 32'h0);
      do_rd("hi_frozen", BASE + 32'h0C, 32'h0);
      do_wr("ctrl_on", BASE + 32'h14, 32'h1);
      do_rd("ctrl_on_rd", BASE + 32'h14, 32'h1);

      @(negedge clk);
      force dut.cyc_q = 64'h0000_0000_FFFF_FFFD;
      @(posedge clk);
      #1;
      release dut.cyc_q;
      txn(1'b0, BASE + 32'h08, 32'h0, lo, lat);
      check("lo_near_wrap", lo[31:4], 28'hFFF_FFFF);
      txn(1'b0, BASE + 32'h0C, 32'h0, hi, lat);
      check("hi_shadow0", hi, 32'h0);
      txn(1'b0, BASE + 32'h08, 32'h0, lo, lat);
      check("lo_wrapped", lo[31:8], 24'h0);
      txn(1'b0, BASE + 32'h0C, 32'h0, hi, lat);
      check("hi_shadow1", hi, 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
